snn_step_scheduler: RTL and testbench
=====================================

// Module: snn_step_scheduler
// PURPOSE
//  Time-step controller for the SNN core. Each time step it:
//  - accepts one input spike vector on an AXI4-stream slave;
//  - issues it to the T neuron blocks in turn (blk_sel 0..T-1) and waits for each block's done;
//  - gathers the N*T output spikes and emits them on an AXI4-stream master.
//  It sits between the host DMA streams and the neuron-block array and runs for run_ts steps.
// PARAMETERS
//  N   32                 neurons per block (snn_pkg::N)
//  T   1                  number of neuron blocks (snn_pkg::T)
//  TA  max(clog2(T),1)    block-select width (snn_pkg::TA)
//  NN  ceil(N*T/8)        tdata width in bytes (snn_pkg::NN)
//  NU  clog2(TS+1)        step/tuser width (snn_pkg::NU)
// PORTS
//  aclk            in   1      clock; all logic on rising edge
//  aresetn         in   1      asynchronous active-low reset
//  start           in   1      1-cycle pulse; begins a run when idle
//  run_ts          in   NU     number of steps; sampled on accepted start
//  busy            out  1      high from accepted start until done
//  done            out  1      1-cycle pulse at end of run
//  seq_err         out  1      sticky: s_tuser != current step seen; cleared on start
//  step            out  NU     current step index
//  s_tvalid        in   1      input spike vector valid
//  s_tready        out  1      input ready
//  s_tdata         in   8*NN   input spikes; bit i = neuron i
//  s_tuser         in   NU     step tag of input vector
//  blk_sel         out  TA     block being driven
//  blk_go          out  1      1-cycle pulse: block blk_sel evaluates blk_spk_in
//  blk_spk_in      out  N*T    latched input spike vector (all blocks see all inputs)
//  blk_done        in   1      selected block finished; blk_spk_out valid this cycle
//  blk_spk_out     in   N      output spikes of block blk_sel
//  m_tvalid        out  1      output spike vector valid
//  m_tready        in   1      downstream ready
//  m_tdata         out  8*NN   gathered output spikes; pad bits above N*T are 0
//  m_tuser         out  NU     step tag (= step)
//  m_tlast         out  1      high on the last step of the run
// BEHAVIOUR
//  - Reset: state IDLE. busy, done, seq_err, s_tready, blk_go, m_tvalid and m_tlast are 0.
//    step, blk_sel, blk_spk_in and m_tdata are 0.
//  - FSM states: IDLE, FETCH, ISSUE, WAIT, EMIT, FIN.
//  - IDLE:
//    - start && run_ts!=0 -> latch run_ts, step=0, seq_err=0, busy=1, go to FETCH.
//    - start && run_ts==0 -> go to FIN. No stream traffic.
//    - start while busy is ignored.
//  - FETCH:
//    - s_tready=1.
//    - On s_tvalid: latch s_tdata[N*T-1:0] into blk_spk_in. Set seq_err if s_tuser!=step.
//    - Then blk_sel=0 and go to ISSUE. s_tready is 0 in every other state.
//  - ISSUE: blk_go=1 for exactly one cycle, then go to WAIT.
//  - WAIT:
//    - On blk_done: write blk_spk_out into gather register slice [blk_sel*N +: N].
//    - If blk_sel==T-1, go to EMIT; else blk_sel+1 and go to ISSUE.
//    - blk_done in any other state is ignored.
//  - EMIT:
//    - m_tvalid=1; m_tdata, m_tuser and m_tlast are held stable until m_tready.
//    - m_tlast = (step==run_ts-1).
//    - On handshake: if last, go to FIN; else step+1 and go to FETCH.
//  - FIN: done=1 for one cycle, busy=0, go to IDLE.
//  - Minimum per-step latency is 2+2T cycles: FETCH 1, T*(ISSUE 1 + WAIT >=1), EMIT 1.
//    This assumes zero-cycle valid/ready stalls.
//  - The gather register is not cleared between steps. Every slice is overwritten each step.
//  - step never wraps: the run ends at run_ts-1, and run_ts <= 2^NU-1.
//  - Asserting aresetn mid-run aborts the run: everything returns to reset values.
//    No done pulse is produced.
// STRUCTURE
//  - snn_pkg gains:
//    - typedef enum logic [2:0] {IDLE,FETCH,ISSUE,WAIT,EMIT,FIN} sched_state_t;
//    - localparam NW = 8*NN.
//  - N, T, TA, NN, NU and TS come from snn_pkg.
//  - One sub-module: snn_spike_gather (N*T-bit register with slice write by blk_sel, zero-padded to NW).
// TESTING
//  1. T=1, run_ts=3, inputs tagged 0,1,2, blk_done 1 cycle after blk_go
//     -> 3 outputs tagged 0,1,2; m_tlast on tag 2 only; done pulses once; seq_err=0.
//  2. run_ts=0 -> done pulses 2 cycles after start; s_tready and m_tvalid never assert.
//  3. T=4, N=8, blk_spk_out=8'h11*(blk_sel+1)
//     -> m_tdata=32'h44332211 with blk_sel seen as 0,1,2,3 in order.
//  4. m_tready held low 5 cycles in EMIT
//     -> m_tvalid, m_tdata and m_tuser stay stable; step is unchanged until handshake.
//  5. Input tagged 5 at step 1 -> seq_err=1, run completes normally, next start clears seq_err.
//  6. aresetn low during WAIT at step 2 -> all outputs 0 next cycle; no done pulse.
//     A new start after reset runs from step 0.

Source files
------------

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared sizing constants and scheduler state type for the SNN core
package snn_pkg;

    localparam int N  = 32;
    localparam int T  = 1;
    localparam int TS = 255;
    localparam int TA = (T > 1) ? $clog2(T) : 1;
    localparam int NN = (N*T + 7) / 8;
    localparam int NU = $clog2(TS + 1);
    localparam int NW = 8*NN;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, EMIT, FIN} sched_state_t;

endpackage

// File: rtl/snn_spike_gather.sv
// rtl/snn_spike_gather.sv - N*T-bit output spike register written one block slice at a time
module snn_spike_gather #(
    parameter int N  = 32,
    parameter int T  = 1,
    parameter int TA = 1,
    parameter int NW = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          wr_en,
    input  logic [TA-1:0] wr_sel,
    input  logic [N-1:0]  wr_data,
    output logic [NW-1:0] gather
);

    logic [N*T-1:0] spk_q;

    // Slices are only overwritten, never cleared: every block rewrites its slice each step.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            spk_q <= '0;
        end else if (wr_en) begin
            spk_q[wr_sel*N +: N] <= wr_data;
        end
    end

    assign gather = NW'(spk_q);

endmodule

// File: rtl/snn_step_scheduler.sv
// rtl/snn_step_scheduler.sv - per-time-step sequencer between host spike streams and neuron blocks
module snn_step_scheduler #(
    parameter int N  = snn_pkg::N,
    parameter int T  = snn_pkg::T,
    parameter int TS = snn_pkg::TS,
    localparam int TA = (T > 1) ? $clog2(T) : 1,
    localparam int NN = (N*T + 7) / 8,
    localparam int NW = 8*NN,
    localparam int NU = $clog2(TS + 1)
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            start,
    input  logic [NU-1:0]   run_ts,
    output logic            busy,
    output logic            done,
    output logic            seq_err,
    output logic [NU-1:0]   step,
    input  logic            s_tvalid,
    output logic            s_tready,
    input  logic [NW-1:0]   s_tdata,
    input  logic [NU-1:0]   s_tuser,
    output logic [TA-1:0]   blk_sel,
    output logic            blk_go,
    output logic [N*T-1:0]  blk_spk_in,
    input  logic            blk_done,
    input  logic [N-1:0]    blk_spk_out,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [NW-1:0]   m_tdata,
    output logic [NU-1:0]   m_tuser,
    output logic            m_tlast
);

    import snn_pkg::*;

    sched_state_t  state, state_n;
    logic [NU-1:0] run_ts_q;
    logic          last_blk;

    assign last_blk = (blk_sel == TA'(T - 1));
    assign m_tuser  = step;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            run_ts_q   <= '0;
            step       <= '0;
            seq_err    <= 1'b0;
            blk_sel    <= '0;
            blk_spk_in <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state == FIN);
            case (state)
                IDLE: if (start) begin
                    run_ts_q <= run_ts;
                    step     <= '0;
                    seq_err  <= 1'b0;
                end
                FETCH: if (s_tvalid) begin
                    blk_spk_in <= s_tdata[N*T-1:0];
                    blk_sel    <= '0;
                    if (s_tuser != step) seq_err <= 1'b1;
                end
                WAIT: if (blk_done && !last_blk) blk_sel <= blk_sel + TA'(1);
                EMIT: if (m_tready && !m_tlast) step <= step + NU'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n  = state;
        busy     = 1'b0;
        s_tready = 1'b0;
        blk_go   = 1'b0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        case (state)
            IDLE: if (start) state_n = (run_ts != '0) ? FETCH : FIN;
            FETCH: begin
                busy     = 1'b1;
                s_tready = 1'b1;
                if (s_tvalid) state_n = ISSUE;
            end
            ISSUE: begin
                busy    = 1'b1;
                blk_go  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (blk_done) state_n = last_blk ? EMIT : ISSUE;
            end
            EMIT: begin
                busy     = 1'b1;
                m_tvalid = 1'b1;
                m_tlast  = (step == run_ts_q - NU'(1));
                if (m_tready) state_n = m_tlast ? FIN : FETCH;
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    snn_spike_gather #(.N(N), .T(T), .TA(TA), .NW(NW)) u_gather (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   ((state == WAIT) && blk_done),
        .wr_sel  (blk_sel),
        .wr_data (blk_spk_out),
        .gather  (m_tdata)
    );

endmodule

// File: tb/tb_snn_step_scheduler.sv
// tb/tb_snn_step_scheduler.sv - directed table-driven bench for snn_step_scheduler
module tb_snn_step_scheduler;

    logic aclk, aresetn;
    int   n_cmp, n_bad, done_cnt;

    // Default configuration: N=32, T=1
    logic        start, busy, done, seq_err, s_tvalid, s_tready, blk_go, blk_done;
    logic        m_tvalid, m_tready, m_tlast, stall1, pend1;
    logic [7:0]  run_ts, step, s_tuser, m_tuser;
    logic [31:0] s_tdata, blk_spk_in, blk_spk_out, m_tdata;
    logic [0:0]  blk_sel;

    // Wide configuration: N=8, T=4
    logic        start4, busy4, done4, seq_err4, s_tvalid4, s_tready4, blk_go4, blk_done4;
    logic        m_tvalid4, m_tready4, m_tlast4, pend4;
    logic [7:0]  run_ts4, step4, s_tuser4, m_tuser4, blk_spk_out4;
    logic [31:0] s_tdata4, blk_spk_in4, m_tdata4;
    logic [1:0]  blk_sel4;
    logic [1:0]  sel_log[$];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        int          hold;
        logic [31:0] exp_data;
        logic [7:0]  exp_tag;
        logic        exp_last;
    } vec_t;
    vec_t tbl[3];

    snn_step_scheduler dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .run_ts(run_ts), .busy(busy),
        .done(done), .seq_err(seq_err), .step(step), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .blk_sel(blk_sel), .blk_go(blk_go),
        .blk_spk_in(blk_spk_in), .blk_done(blk_done), .blk_spk_out(blk_spk_out),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
        .m_tlast(m_tlast)
    );

    snn_step_scheduler #(.N(8), .T(4), .TS(255)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .start(start4), .run_ts(run_ts4), .busy(busy4),
        .done(done4), .seq_err(seq_err4), .step(step4), .s_tvalid(s_tvalid4), .s_tready(s_tready4),
        .s_tdata(s_tdata4), .s_tuser(s_tuser4), .blk_sel(blk_sel4), .blk_go(blk_go4),
        .blk_spk_in(blk_spk_in4), .blk_done(blk_done4), .blk_spk_out(blk_spk_out4),
        .m_tvalid(m_tvalid4), .m_tready(m_tready4), .m_tdata(m_tdata4), .m_tuser(m_tuser4),
        .m_tlast(m_tlast4)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Block model: answers one cycle after blk_go with the inverted input vector
    initial begin
        blk_done = 1'b0; blk_spk_out = '0; pend1 = 1'b0;
        forever begin
            @(negedge aclk);
            blk_done = 1'b0;
            if (!aresetn) pend1 = 1'b0;
            else if (pend1 && !stall1) begin
                blk_done = 1'b1; blk_spk_out = ~blk_spk_in; pend1 = 1'b0;
            end
            if (blk_go) pend1 = 1'b1;
        end
    end

    initial begin
        blk_done4 = 1'b0; blk_spk_out4 = '0; pend4 = 1'b0;
        forever begin
            @(negedge aclk);
            blk_done4 = 1'b0;
            if (pend4) begin
                blk_done4 = 1'b1; blk_spk_out4 = 8'(8'h11 * (8'(blk_sel4) + 8'd1)); pend4 = 1'b0;
            end
            if (blk_go4) begin pend4 = 1'b1; sel_log.push_back(blk_sel4); end
        end
    end

    initial begin
        done_cnt = 0;
        forever begin
            @(negedge aclk);
            if (done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, seq_err, s_tready, blk_go, m_tvalid, m_tlast}), 64'd0);
        check({tag, "_step"}, 64'(step), 64'd0);
        check({tag, "_blk_sel"}, 64'(blk_sel), 64'd0);
        check({tag, "_blk_spk_in"}, 64'(blk_spk_in), 64'd0);
        check({tag, "_m_tdata"}, 64'(m_tdata), 64'd0);
    endtask

    task automatic start_run(input logic [7:0] n);
        start = 1'b1; run_ts = n;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic send1(input logic [31:0] d, input logic [7:0] tag);
        int k = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tuser = tag;
        while (!s_tready && k < 50) begin @(negedge aclk); k++; end
        check("s_tready_wait", 64'(s_tready), 64'd1);
        @(negedge aclk);
        s_tvalid = 1'b0;
    endtask

    task automatic recv1(input vec_t v);
        int k = 0;
        while (!m_tvalid && k < 50) begin @(negedge aclk); k++; end
        check("m_tvalid_wait", 64'(m_tvalid), 64'd1);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge aclk);
            check("hold_m_tvalid", 64'(m_tvalid), 64'd1);
            check("hold_m_tdata", 64'(m_tdata), 64'(v.exp_data));
            check("hold_m_tuser", 64'(m_tuser), 64'(v.exp_tag));
            check("hold_step", 64'(step), 64'(v.exp_tag));
        end
        check("m_tdata", 64'(m_tdata), 64'(v.exp_data));
        check("m_tuser", 64'(m_tuser), 64'(v.exp_tag));
        check("m_tlast", 64'(m_tlast), 64'(v.exp_last));
        m_tready = 1'b1;
        @(negedge aclk);
        m_tready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic [7:0] tag, input logic last);
        vec_t v;
        v.data = d; v.tag = tag; v.hold = 0;
        v.exp_data = ~d; v.exp_tag = tag; v.exp_last = last;
        return v;
    endfunction

    initial begin
        int d0, k;
        n_cmp = 0; n_bad = 0; stall1 = 1'b0;
        aresetn = 1'b0;
        start = 1'b0; run_ts = '0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; m_tready = 1'b0;
        start4 = 1'b0; run_ts4 = '0; s_tvalid4 = 1'b0; s_tdata4 = '0; s_tuser4 = '0; m_tready4 = 1'b0;

        tbl[0] = '{32'hA5A5_0001, 8'd0, 0, 32'h5A5A_FFFE, 8'd0, 1'b0};
        tbl[1] = '{32'h0000_FFFF, 8'd1, 5, 32'hFFFF_0000, 8'd1, 1'b0};
        tbl[2] = '{32'h8000_0001, 8'd2, 0, 32'h7FFF_FFFE, 8'd2, 1'b1};

        repeat (3) @(negedge aclk);
        check_reset("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        // Three-step run, middle step back-pressured for 5 cycles
        d0 = done_cnt;
        start_run(8'd3);
        check("busy_after_start", 64'(busy), 64'd1);
        check("step_after_start", 64'(step), 64'd0);
        for (int i = 0; i < 3; i++) begin
            send1(tbl[i].data, tbl[i].tag);
            recv1(tbl[i]);
        end
        repeat (3) @(negedge aclk);
        check("run3_done_count", 64'(done_cnt - d0), 64'd1);
        check("run3_seq_err", 64'(seq_err), 64'd0);
        check("run3_busy_end", 64'(busy), 64'd0);

        // Zero-length run
        start_run(8'd0);
        check("zero_c1", 64'({done, s_tready, m_tvalid, busy}), 64'd0);
        @(negedge aclk);
        check("zero_c2_done", 64'(done), 64'd1);
        check("zero_c2_streams", 64'({s_tready, m_tvalid}), 64'd0);
        @(negedge aclk);
        check("zero_c3", 64'({done, s_tready, m_tvalid}), 64'd0);

        // Wrong step tag on step 1
        start_run(8'd3);
        send1(32'h1234_5678, 8'd0);
        recv1(mk(32'h1234_5678, 8'd0, 1'b0));
        check("seq_ok_step0", 64'(seq_err), 64'd0);
        send1(32'h0F0F_0F0F, 8'd5);
        check("seq_err_set", 64'(seq_err), 64'd1);
        recv1(mk(32'h0F0F_0F0F, 8'd1, 1'b0));
        send1(32'hCAFE_F00D, 8'd2);
        recv1(mk(32'hCAFE_F00D, 8'd2, 1'b1));
        d0 = done_cnt;
        repeat (3) @(negedge aclk);
        check("seq_run_done", 64'(done_cnt - d0), 64'd1);
        check("seq_err_sticky", 64'(seq_err), 64'd1);
        start_run(8'd1);
        check("seq_err_cleared", 64'(seq_err), 64'd0);
        send1(32'h0000_0000, 8'd0);
        recv1(mk(32'h0000_0000, 8'd0, 1'b1));
        repeat (3) @(negedge aclk);

        // Abort by reset while waiting on a block at step 2
        start_run(8'd4);
        send1(32'h1111_1111, 8'd0);
        recv1(mk(32'h1111_1111, 8'd0, 1'b0));
        send1(32'h2222_2222, 8'd1);
        recv1(mk(32'h2222_2222, 8'd1, 1'b0));
        stall1 = 1'b1;
        send1(32'h3333_3333, 8'd2);
        @(negedge aclk);
        check("abort_in_wait", 64'({busy, blk_go, m_tvalid, step}), 64'({1'b1, 1'b0, 1'b0, 8'd2}));
        d0 = done_cnt;
        aresetn = 1'b0;
        @(negedge aclk);
        check_reset("abort");
        aresetn = 1'b1;
        stall1 = 1'b0;
        repeat (3) @(negedge aclk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        start_run(8'd1);
        check("restart_step", 64'(step), 64'd0);
        send1(32'h4444_4444, 8'd0);
        recv1(mk(32'h4444_4444, 8'd0, 1'b1));
        repeat (3) @(negedge aclk);

        // Four blocks of eight neurons
        sel_log.delete();
        start4 = 1'b1; run_ts4 = 8'd1;
        @(negedge aclk);
        start4 = 1'b0;
        s_tvalid4 = 1'b1; s_tdata4 = 32'hDEAD_BEEF; s_tuser4 = 8'd0;
        k = 0;
        while (!s_tready4 && k < 50) begin @(negedge aclk); k++; end
        check("t4_s_tready", 64'(s_tready4), 64'd1);
        @(negedge aclk);
        s_tvalid4 = 1'b0;
        k = 0;
        while (!m_tvalid4 && k < 100) begin @(negedge aclk); k++; end
        check("t4_m_tvalid", 64'(m_tvalid4), 64'd1);
        check("t4_m_tdata", 64'(m_tdata4), 64'h4433_2211);
        check("t4_m_tlast", 64'(m_tlast4), 64'd1);
        check("t4_blk_spk_in", 64'(blk_spk_in4), 64'hDEAD_BEEF);
        m_tready4 = 1'b1;
        @(negedge aclk);
        m_tready4 = 1'b0;
        check("t4_sel_count", 64'(sel_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < sel_log.size()) check("t4_sel_order", 64'(sel_log[i]), 64'(i));
        end
        @(negedge aclk);
        check("t4_done", 64'(done4), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
